// File: rtl/mem_port_arbiter_if.sv
// Valid/ready request and response channel between a requester and a memory port.
// master: the side that issues requests and consumes responses.
// slave:  the side that accepts requests and produces responses.
interface mem_port_arbiter_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                   req_valid;
   logic                   req_ready;
   logic [AddrWidth-1:0]   req_addr;
   logic                   req_we;
   logic [DataWidth-1:0]   req_wdata;
   logic [DataWidth/8-1:0] req_wstrb;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DataWidth-1:0]   rsp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// Round-robin grant, request held stable under backpressure, in-order
// responses routed back through a small order FIFO of requester ids.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_OPEN | no request pending; winner chosen round-robin each cycle
// ST_HELD | a request was presented but not accepted; r_owner keeps the port
module mem_port_arbiter #(
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   mem_port_arbiter_if.slave       i_port,
   mem_port_arbiter_if.slave       d_port,
   mem_port_arbiter_if.master      mem_port,
   output logic                    err_o
);
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic {ST_OPEN, ST_HELD} state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_owner, w_owner_nxt;
   logic                    r_last, w_last_nxt;
   logic [MaxOutstanding-1:0] r_fifo;
   logic [PtrW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CntW-1:0]         r_count;
   logic                    r_err;

   logic w_run, w_can_issue, w_winner, w_sel, w_sel_valid;
   logic w_mem_valid, w_push, w_pop, w_empty, w_head;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Outputs are forced quiet while reset is held, even with requesters still valid.
   assign w_run       = ~rst_i;
   assign w_can_issue = (r_count < CntW'(MaxOutstanding));

   // Round-robin winner among the currently valid requesters.
   always_comb begin
      w_winner = ~r_last;
      if (i_port.req_valid && !d_port.req_valid)
         w_winner = PORT_I;
      else if (d_port.req_valid && !i_port.req_valid)
         w_winner = PORT_D;
   end

   assign w_sel       = (r_state == ST_HELD) ? r_owner : w_winner;
   assign w_sel_valid = w_sel ? d_port.req_valid : i_port.req_valid;
   assign w_mem_valid = w_run & w_can_issue & w_sel_valid;
   assign w_push      = w_mem_valid & mem_port.req_ready;

   assign mem_port.req_valid = w_mem_valid;
   assign mem_port.req_addr  = w_sel ? d_port.req_addr  : i_port.req_addr;
   assign mem_port.req_we    = w_sel ? d_port.req_we    : i_port.req_we;
   assign mem_port.req_wdata = w_sel ? d_port.req_wdata : i_port.req_wdata;
   assign mem_port.req_wstrb = w_sel ? d_port.req_wstrb : i_port.req_wstrb;

   // req_ready depends only on registered count and the downstream ready, never on responses.
   assign i_port.req_ready = w_run & mem_port.req_ready & w_can_issue & (w_sel == PORT_I);
   assign d_port.req_ready = w_run & mem_port.req_ready & w_can_issue & (w_sel == PORT_D);

   // Lock/round-robin next state: stall locks the owner, acceptance releases it.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      if (w_mem_valid && !mem_port.req_ready) begin
         w_state_nxt = ST_HELD;
         w_owner_nxt = w_sel;
      end else if (w_push) begin
         w_state_nxt = ST_OPEN;
         w_last_nxt  = w_sel;
      end
   end

   // Arbitration state register; last starts at I so D wins the first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_OPEN;
         r_owner <= PORT_I;
         r_last  <= PORT_I;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
      end
   end

   assign w_empty = (r_count == '0);
   assign w_head  = r_fifo[r_rd_ptr];

   assign i_port.rsp_valid = w_run & ~w_empty & (w_head == PORT_I) & mem_port.rsp_valid;
   assign d_port.rsp_valid = w_run & ~w_empty & (w_head == PORT_D) & mem_port.rsp_valid;
   assign i_port.rsp_rdata = mem_port.rsp_rdata;
   assign d_port.rsp_rdata = mem_port.rsp_rdata;
   // An unexpected response with nothing outstanding is swallowed so the bus cannot hang.
   assign mem_port.rsp_ready = w_run & (w_empty | (w_head ? d_port.rsp_ready : i_port.rsp_ready));
   assign w_pop = mem_port.rsp_valid & mem_port.rsp_ready & ~w_empty;

   // Order FIFO of requester ids; push and pop in the same cycle leave count unchanged.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fifo   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
            r_wr_ptr         <= ptr_inc(r_wr_ptr);
         end
         if (w_pop)
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)
            r_count <= r_count + CntW'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - CntW'(1);
      end
   end

   // Sticky error for a response that arrives with no request outstanding.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_err <= 1'b0;
      else if (mem_port.rsp_valid && w_empty)
         r_err <= 1'b1;
   end

   assign err_o = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, backpressure lock,
// outstanding limit, in-order response routing, error flag, async reset.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic err;
   int   n_assert = 0;
   int   n_fail   = 0;

   mem_port_arbiter_if #(.AddrWidth(32), .DataWidth(32)) if_i ();
   mem_port_arbiter_if #(.AddrWidth(32), .DataWidth(32)) if_d ();
   mem_port_arbiter_if #(.AddrWidth(32), .DataWidth(32)) if_mem ();

   mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(4)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .i_port   (if_i),
      .d_port   (if_d),
      .mem_port (if_mem),
      .err_o    (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic grant_d [4];
   int   nd, ni;
   logic [31:0] exp_rd;

   initial begin
      grant_d = '{1'b1, 1'b0, 1'b1, 1'b0};
      nd = 0;
      ni = 0;
      rst = 1'b1;
      if_i.req_valid = 1'b1; if_i.req_addr = 32'h1000; if_i.req_we = 1'b0;
      if_i.req_wdata = 32'h0; if_i.req_wstrb = 4'hF; if_i.rsp_ready = 1'b1;
      if_d.req_valid = 1'b1; if_d.req_addr = 32'h2000; if_d.req_we = 1'b1;
      if_d.req_wdata = 32'h1234; if_d.req_wstrb = 4'h3; if_d.rsp_ready = 1'b1;
      if_mem.req_ready = 1'b1; if_mem.rsp_valid = 1'b0; if_mem.rsp_rdata = 32'h0;

      // Reset: all outputs quiet despite active inputs
      #3;
      chk1("rst_mem_valid", if_mem.req_valid, 1'b0);
      chk1("rst_i_ready", if_i.req_ready, 1'b0);
      chk1("rst_d_ready", if_d.req_ready, 1'b0);
      chk1("rst_rsp_ready", if_mem.rsp_ready, 1'b0);
      chk1("rst_err", err, 1'b0);
      tick();
      rst = 1'b0;

      // Both requesters valid every cycle, one-cycle response latency
      for (int k = 0; k < 5; k++) begin
         if_i.req_valid = (k < 4);
         if_d.req_valid = (k < 4);
         if_mem.rsp_valid = (k >= 1);
         exp_rd = 32'h0;
         if (k >= 1) begin
            exp_rd = grant_d[k-1] ? (32'hD000_0000 + 32'(nd)) : (32'h1000_0000 + 32'(ni));
            if_mem.rsp_rdata = exp_rd;
         end
         settle();
         if (k < 4) begin
            chk1("t1_mem_valid", if_mem.req_valid, 1'b1);
            chk1("t1_d_ready", if_d.req_ready, grant_d[k]);
            chk1("t1_i_ready", if_i.req_ready, ~grant_d[k]);
            chk32("t1_addr", if_mem.req_addr, grant_d[k] ? 32'h2000 : 32'h1000);
         end
         if (k >= 1) begin
            chk1("t1_d_rsp_valid", if_d.rsp_valid, grant_d[k-1]);
            chk1("t1_i_rsp_valid", if_i.rsp_valid, ~grant_d[k-1]);
            chk32("t1_rdata", grant_d[k-1] ? if_d.rsp_rdata : if_i.rsp_rdata, exp_rd);
            if (grant_d[k-1]) nd++; else ni++;
         end
         tick();
      end
      if_mem.rsp_valid = 1'b0;

      // D at 0x80 stalled three cycles while I waits
      if_i.req_valid = 1'b1; if_d.req_valid = 1'b1; if_d.req_addr = 32'h80;
      if_mem.req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk32("t2_stall_addr", if_mem.req_addr, 32'h80);
         chk1("t2_stall_valid", if_mem.req_valid, 1'b1);
         chk1("t2_stall_i_ready", if_i.req_ready, 1'b0);
         tick();
      end
      if_mem.req_ready = 1'b1;
      settle();
      chk1("t2_d_ready", if_d.req_ready, 1'b1);
      chk1("t2_i_ready_low", if_i.req_ready, 1'b0);
      chk32("t2_accept_addr", if_mem.req_addr, 32'h80);
      tick();
      settle();
      chk1("t2_next_i_ready", if_i.req_ready, 1'b1);
      chk1("t2_next_d_ready", if_d.req_ready, 1'b0);
      chk32("t2_next_addr", if_mem.req_addr, 32'h1000);
      tick();
      if_i.req_valid = 1'b0; if_d.req_valid = 1'b0;
      if_mem.rsp_valid = 1'b1; if_mem.rsp_rdata = 32'h55;
      settle();
      chk1("t2_drain_d", if_d.rsp_valid, 1'b1);
      chk1("t2_drain_d_i", if_i.rsp_valid, 1'b0);
      tick();
      if_mem.rsp_rdata = 32'h66;
      settle();
      chk1("t2_drain_i", if_i.rsp_valid, 1'b1);
      tick();
      if_mem.rsp_valid = 1'b0;

      // Outstanding limit of four
      if_i.req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk1("t3_issue_ready", if_i.req_ready, 1'b1);
         tick();
      end
      settle();
      chk1("t3_full_valid", if_mem.req_valid, 1'b0);
      chk1("t3_full_ready", if_i.req_ready, 1'b0);
      if_mem.rsp_valid = 1'b1; if_mem.rsp_rdata = 32'h77;
      settle();
      chk1("t3_pop_rsp", if_i.rsp_valid, 1'b1);
      chk1("t3_pop_no_issue", if_mem.req_valid, 1'b0);
      tick();
      if_mem.rsp_valid = 1'b0;
      settle();
      chk1("t3_reissue_valid", if_mem.req_valid, 1'b1);
      chk1("t3_reissue_ready", if_i.req_ready, 1'b1);
      tick();
      if_i.req_valid = 1'b0;
      if_mem.rsp_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk1("t3_drain", if_i.rsp_valid, 1'b1);
         tick();
      end
      if_mem.rsp_valid = 1'b0;

      // Order I,D,I with a two-cycle stall on the D response
      if_i.req_valid = 1'b1;
      settle();
      chk1("t4_iss_i0", if_i.req_ready, 1'b1);
      tick();
      if_i.req_valid = 1'b0; if_d.req_valid = 1'b1;
      settle();
      chk1("t4_iss_d", if_d.req_ready, 1'b1);
      tick();
      if_d.req_valid = 1'b0; if_i.req_valid = 1'b1;
      settle();
      chk1("t4_iss_i1", if_i.req_ready, 1'b1);
      tick();
      if_i.req_valid = 1'b0;
      if_mem.rsp_valid = 1'b1; if_mem.rsp_rdata = 32'hA; if_d.rsp_ready = 1'b0;
      settle();
      chk1("t4_a_valid", if_i.rsp_valid, 1'b1);
      chk32("t4_a_data", if_i.rsp_rdata, 32'hA);
      chk1("t4_a_ready", if_mem.rsp_ready, 1'b1);
      chk1("t4_a_d_valid", if_d.rsp_valid, 1'b0);
      tick();
      if_mem.rsp_rdata = 32'hB;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk1("t4_stall_d_valid", if_d.rsp_valid, 1'b1);
         chk1("t4_stall_ready", if_mem.rsp_ready, 1'b0);
         tick();
      end
      if_d.rsp_ready = 1'b1;
      settle();
      chk1("t4_b_ready", if_mem.rsp_ready, 1'b1);
      chk1("t4_b_valid", if_d.rsp_valid, 1'b1);
      chk32("t4_b_data", if_d.rsp_rdata, 32'hB);
      tick();
      if_mem.rsp_rdata = 32'hC;
      settle();
      chk1("t4_c_valid", if_i.rsp_valid, 1'b1);
      chk1("t4_c_d_valid", if_d.rsp_valid, 1'b0);
      chk32("t4_c_data", if_i.rsp_rdata, 32'hC);
      tick();
      if_mem.rsp_valid = 1'b0;

      // Response with nothing outstanding sets a sticky error
      if_mem.rsp_valid = 1'b1; if_mem.rsp_rdata = 32'hEE;
      settle();
      chk1("t5_drop_ready", if_mem.rsp_ready, 1'b1);
      chk1("t5_drop_i", if_i.rsp_valid, 1'b0);
      chk1("t5_drop_d", if_d.rsp_valid, 1'b0);
      tick();
      if_mem.rsp_valid = 1'b0;
      settle();
      chk1("t5_err_set", err, 1'b1);
      if_i.req_valid = 1'b1;
      tick();
      if_i.req_valid = 1'b0; if_mem.rsp_valid = 1'b1;
      settle();
      chk1("t5_traffic_rsp", if_i.rsp_valid, 1'b1);
      tick();
      if_mem.rsp_valid = 1'b0;
      settle();
      chk1("t5_err_sticky", err, 1'b1);

      // Two outstanding, D locked under stall, then async reset
      if_i.req_valid = 1'b1;
      tick();
      if_i.req_valid = 1'b0; if_d.req_valid = 1'b1; if_d.req_addr = 32'h2000;
      tick();
      if_mem.req_ready = 1'b0;
      settle();
      chk1("t6_stall_valid", if_mem.req_valid, 1'b1);
      chk32("t6_stall_addr", if_mem.req_addr, 32'h2000);
      tick();
      if_i.req_valid = 1'b1;
      settle();
      chk32("t6_locked_addr", if_mem.req_addr, 32'h2000);
      chk1("t6_locked_i_ready", if_i.req_ready, 1'b0);
      rst = 1'b1;
      if_mem.rsp_valid = 1'b1;
      #1;
      chk1("t6_rst_mem_valid", if_mem.req_valid, 1'b0);
      chk1("t6_rst_i_ready", if_i.req_ready, 1'b0);
      chk1("t6_rst_d_ready", if_d.req_ready, 1'b0);
      chk1("t6_rst_i_rsp", if_i.rsp_valid, 1'b0);
      chk1("t6_rst_d_rsp", if_d.rsp_valid, 1'b0);
      chk1("t6_rst_rsp_ready", if_mem.rsp_ready, 1'b0);
      chk32("t6_rst_count", 32'(dut.r_count), 32'h0);
      chk1("t6_rst_err", err, 1'b0);
      if_mem.rsp_valid = 1'b0;
      if_mem.req_ready = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk1("t6_tie_d_ready", if_d.req_ready, 1'b1);
      chk1("t6_tie_i_ready", if_i.req_ready, 1'b0);
      chk32("t6_tie_addr", if_mem.req_addr, 32'h2000);
      chk1("t6_err_clear", err, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
